alu_sequencer: RTL and testbench

- Multi-cycle controller that sequences the shared 16-bit ALU: accepts one instruction at a time over a valid/ready handshake and reads operands from an internal 16x16 register file.
- Drives the ALU's A/B/Opcode inputs, captures C and the five status outputs, writes the result back and updates a processor status register (PSR).
- Sits between instruction decode and the combinational ALU, which stays external.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_regfile.sv | 45 ++++
 rtl/alu_sequencer.sv | 143 ++++++++++++++
 tb/tb_alu_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared widths, FSM encoding and PSR bit layout for the ALU sequencer
// Purpose: single source for the datapath/opcode/address widths, the
//          sequencer state encoding and the PSR bit positions.
// Ports  : none (package).
package alu_pkg;

  localparam int DATA_W = 16;
  localparam int OP_W   = 8;
  localparam int ADDR_W = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_WB   = 2'd3;

  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;

endpackage

// File: rtl/alu_regfile.sv
// rtl/alu_regfile.sv - 2**ADDR_W x DATA_W register file, two async reads + debug read, one sync write
// Purpose: operand storage for the ALU sequencer.
// Ports  : clk, reset_n (async clear)
//          i_raddr_a/o_rdata_a, i_raddr_b/o_rdata_b : operand read ports
//          i_dbg_addr/o_dbg_data                    : debug read port
//          i_we, i_waddr, i_wdata                   : write port (rising edge)
module alu_regfile
  import alu_pkg::*;
#(
  parameter int RF_DATA_W = alu_pkg::DATA_W,
  parameter int RF_ADDR_W = alu_pkg::ADDR_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [RF_ADDR_W-1:0] i_raddr_a,
  output logic [RF_DATA_W-1:0] o_rdata_a,
  input  logic [RF_ADDR_W-1:0] i_raddr_b,
  output logic [RF_DATA_W-1:0] o_rdata_b,
  input  logic [RF_ADDR_W-1:0] i_dbg_addr,
  output logic [RF_DATA_W-1:0] o_dbg_data,
  input  logic                 i_we,
  input  logic [RF_ADDR_W-1:0] i_waddr,
  input  logic [RF_DATA_W-1:0] i_wdata
);

  localparam int DEPTH = 2 ** RF_ADDR_W;

  logic [RF_DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  // Reads are combinational, so a write is seen on the cycle after it lands.
  assign o_rdata_a  = r_mem[i_raddr_a];
  assign o_rdata_b  = r_mem[i_raddr_b];
  assign o_dbg_data = r_mem[i_dbg_addr];

endmodule

// File: rtl/alu_sequencer.sv
// rtl/alu_sequencer.sv - four-state controller sequencing one instruction through an external ALU
// Purpose: accept an instruction, fetch operands, drive the ALU, capture C and
//          status, write back and update the PSR.
// Ports  : clk, reset_n (async, active low)
//          instr_valid/instr_ready + instr_* fields : instruction handshake
//          alu_a, alu_b, alu_opcode                  : registered ALU drive
//          alu_c + alu_{carry,flag,low,negative,zero}: ALU results
//          psr {N,Z,F,L,C}, done (one-cycle retire pulse)
//          dbg_addr/dbg_data                         : combinational regfile peek
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::DATA_W,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int ADDR_W = alu_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   instr_opcode,
  input  logic [ADDR_W-1:0] instr_rdest,
  input  logic [ADDR_W-1:0] instr_rsrc,
  input  logic [DATA_W-1:0] instr_imm,
  input  logic              instr_use_imm,
  input  logic              instr_wb,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_opcode,
  input  logic [DATA_W-1:0] alu_c,
  input  logic              alu_carry,
  input  logic              alu_flag,
  input  logic              alu_low,
  input  logic              alu_negative,
  input  logic              alu_zero,
  output logic [4:0]        psr,
  output logic              done,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [1:0]        r_state;
  logic [OP_W-1:0]   r_opcode;
  logic [ADDR_W-1:0] r_rdest;
  logic [ADDR_W-1:0] r_rsrc;
  logic [DATA_W-1:0] r_imm;
  logic              r_use_imm;
  logic              r_wb;
  logic [DATA_W-1:0] r_alu_a;
  logic [DATA_W-1:0] r_alu_b;
  logic [OP_W-1:0]   r_alu_opcode;
  logic [DATA_W-1:0] r_result;
  logic [4:0]        r_flags;
  logic [4:0]        r_psr;
  logic              r_done;

  logic [DATA_W-1:0] w_rd_a;
  logic [DATA_W-1:0] w_rd_b;
  logic              w_we;

  assign w_we = (r_state == ST_WB) && r_wb;

  alu_regfile #(
    .RF_DATA_W (DATA_W),
    .RF_ADDR_W (ADDR_W)
  ) u_regfile (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_raddr_a  (r_rdest),
    .o_rdata_a  (w_rd_a),
    .i_raddr_b  (r_rsrc),
    .o_rdata_b  (w_rd_b),
    .i_dbg_addr (dbg_addr),
    .o_dbg_data (dbg_data),
    .i_we       (w_we),
    .i_waddr    (r_rdest),
    .i_wdata    (r_result)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_opcode     <= '0;
      r_rdest      <= '0;
      r_rsrc       <= '0;
      r_imm        <= '0;
      r_use_imm    <= 1'b0;
      r_wb         <= 1'b0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_alu_opcode <= '0;
      r_result     <= '0;
      r_flags      <= '0;
      r_psr        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (instr_valid) begin
            r_opcode  <= instr_opcode;
            r_rdest   <= instr_rdest;
            r_rsrc    <= instr_rsrc;
            r_imm     <= instr_imm;
            r_use_imm <= instr_use_imm;
            r_wb      <= instr_wb;
            r_state   <= ST_READ;
          end
        end
        ST_READ: begin
          r_alu_a      <= w_rd_a;
          r_alu_b      <= r_use_imm ? r_imm : w_rd_b;
          r_alu_opcode <= r_opcode;
          r_state      <= ST_EXEC;
        end
        ST_EXEC: begin
          r_result              <= alu_c;
          r_flags[PSR_N]        <= alu_negative;
          r_flags[PSR_Z]        <= alu_zero;
          r_flags[PSR_F]        <= alu_flag;
          r_flags[PSR_L]        <= alu_low;
          r_flags[PSR_C]        <= alu_carry;
          // done is registered here so it is high exactly during WB.
          r_done                <= 1'b1;
          r_state               <= ST_WB;
        end
        ST_WB: begin
          r_psr   <= r_flags;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign instr_ready = (r_state == ST_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_opcode  = r_alu_opcode;
  assign psr         = r_psr;
  assign done        = r_done;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb/tb_alu_sequencer.sv - self-checking bench for alu_sequencer with an ALU stub and reference model
module tb_alu_sequencer;

  logic        clk;
  logic        reset_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  instr_opcode;
  logic [3:0]  instr_rdest;
  logic [3:0]  instr_rsrc;
  logic [15:0] instr_imm;
  logic        instr_use_imm;
  logic        instr_wb;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [7:0]  alu_opcode;
  logic [15:0] alu_c;
  logic        alu_carry;
  logic        alu_flag;
  logic        alu_low;
  logic        alu_negative;
  logic        alu_zero;
  logic [4:0]  psr;
  logic        done;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr_opcode  (instr_opcode),
    .instr_rdest   (instr_rdest),
    .instr_rsrc    (instr_rsrc),
    .instr_imm     (instr_imm),
    .instr_use_imm (instr_use_imm),
    .instr_wb      (instr_wb),
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_opcode    (alu_opcode),
    .alu_c         (alu_c),
    .alu_carry     (alu_carry),
    .alu_flag      (alu_flag),
    .alu_low       (alu_low),
    .alu_negative  (alu_negative),
    .alu_zero      (alu_zero),
    .psr           (psr),
    .done          (done),
    .dbg_addr      (dbg_addr),
    .dbg_data      (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ALU stub: 05 = add with carry out, anything else = xor with equal/less flags.
  logic [16:0] stub_sum;
  always_comb begin
    stub_sum = {1'b0, alu_a} + {1'b0, alu_b};
    if (alu_opcode == 8'h05) begin
      alu_c     = stub_sum[15:0];
      alu_carry = stub_sum[16];
      alu_flag  = 1'b0;
      alu_low   = 1'b0;
    end else begin
      alu_c     = alu_a ^ alu_b;
      alu_carry = 1'b0;
      alu_flag  = (alu_a == alu_b);
      alu_low   = (alu_a < alu_b);
    end
    alu_negative = alu_c[15];
    alu_zero     = (alu_c == 16'h0000);
  end

  int n_cmp;
  int n_fail;

  logic [15:0] m_reg [16];
  logic [4:0]  m_psr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: expected {psr, C} from integer arithmetic on the operand values.
  function automatic logic [20:0] ref_alu(input logic [7:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    int unsigned s;
    logic [15:0] c;
    logic cy, f, l;
    s = 32'(a) + 32'(b);
    if (op == 8'h05) begin
      c  = 16'(s % 65536);
      cy = (s >= 65536);
      f  = 1'b0;
      l  = 1'b0;
    end else begin
      c  = a ^ b;
      cy = 1'b0;
      f  = (a == b);
      l  = (int'(a) < int'(b));
    end
    return {c >= 16'h8000, c == 16'h0000, f, l, cy, c};
  endfunction

  task automatic model_exec(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                            input logic [15:0] imm, input logic ui, input logic wb);
    logic [20:0] r;
    r = ref_alu(op, m_reg[rd], ui ? imm : m_reg[rs]);
    if (wb) m_reg[rd] = r[15:0];
    m_psr = r[20:16];
  endtask

  task automatic check_all_regs(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i);
      #1;
      check($sformatf("%s reg%0d", tag, i), dbg_data, m_reg[i]);
    end
  endtask

  task automatic run_instr(input logic [7:0] op, input logic [3:0] rd, input logic [3:0] rs,
                           input logic [15:0] imm, input logic ui, input logic wb,
                           input string tag,
                           output logic [15:0] got_a, output logic [15:0] got_b,
                           output logic [4:0] got_psr, output logic [15:0] got_dst);
    int          waitc;
    logic [15:0] ea, eb, old;
    waitc = 0;
    @(negedge clk);
    while (!instr_ready && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " ready_wait"}, instr_ready, 1);
    ea  = m_reg[rd];
    eb  = ui ? imm : m_reg[rs];
    old = m_reg[rd];
    instr_opcode  = op;
    instr_rdest   = rd;
    instr_rsrc    = rs;
    instr_imm     = imm;
    instr_use_imm = ui;
    instr_wb      = wb;
    instr_valid   = 1'b1;
    dbg_addr      = rd;
    @(posedge clk);
    #1;
    instr_valid   = 1'b0;
    instr_opcode  = 8'($urandom);
    instr_rdest   = 4'($urandom);
    instr_rsrc    = 4'($urandom);
    instr_imm     = 16'($urandom);
    instr_use_imm = 1'($urandom);
    instr_wb      = 1'($urandom);
    @(negedge clk);
    check({tag, " read ready"}, instr_ready, 0);
    check({tag, " read done"}, done, 0);
    @(negedge clk);
    got_a = alu_a;
    got_b = alu_b;
    check({tag, " exec alu_a"}, alu_a, ea);
    check({tag, " exec alu_b"}, alu_b, eb);
    check({tag, " exec alu_opcode"}, alu_opcode, op);
    check({tag, " exec done"}, done, 0);
    @(negedge clk);
    check({tag, " wb done"}, done, 1);
    check({tag, " wb ready"}, instr_ready, 0);
    check({tag, " wb dbg old"}, dbg_data, old);
    model_exec(op, rd, rs, imm, ui, wb);
    @(negedge clk);
    got_psr = psr;
    got_dst = dbg_data;
    check({tag, " idle done"}, done, 0);
    check({tag, " idle ready"}, instr_ready, 1);
    check({tag, " psr"}, psr, m_psr);
    check({tag, " dst"}, dbg_data, m_reg[rd]);
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs;
    logic [15:0] imm;
    logic        ui;
    logic        wb;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
    logic [4:0]  exp_psr;
    logic [15:0] exp_dst;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] ga, gb, gd;
    logic [4:0]  gp;
    int          accepts [$];
    int          n_done;
    int          ok_gap;

    n_cmp = 0;
    n_fail = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_psr = 5'b00000;

    //            op     rd    rs    imm       ui    wb    a         b         psr       dst
    vecs[0] = '{8'h05, 4'd1, 4'd0, 16'h0007, 1'b1, 1'b1, 16'h0000, 16'h0007, 5'b00000, 16'h0007};
    vecs[1] = '{8'h05, 4'd2, 4'd0, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 16'hFFFF, 5'b10000, 16'hFFFF};
    vecs[2] = '{8'h05, 4'd2, 4'd0, 16'h0001, 1'b1, 1'b1, 16'hFFFF, 16'h0001, 5'b01001, 16'h0000};
    vecs[3] = '{8'h05, 4'd1, 4'd2, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h0000, 5'b00000, 16'h0007};
    vecs[4] = '{8'h05, 4'd3, 4'd1, 16'h0000, 1'b0, 1'b1, 16'h0000, 16'h0007, 5'b00000, 16'h0007};
    vecs[5] = '{8'h05, 4'd3, 4'd3, 16'h0000, 1'b0, 1'b1, 16'h0007, 16'h0007, 5'b00000, 16'h000E};
    vecs[6] = '{8'h33, 4'd1, 4'd3, 16'h0000, 1'b0, 1'b0, 16'h0007, 16'h000E, 5'b00010, 16'h0007};
    vecs[7] = '{8'h33, 4'd4, 4'd0, 16'h0000, 1'b1, 1'b1, 16'h0000, 16'h0000, 5'b01100, 16'h0000};

    reset_n       = 1'b0;
    instr_valid   = 1'b0;
    instr_opcode  = 8'h00;
    instr_rdest   = 4'd0;
    instr_rsrc    = 4'd0;
    instr_imm     = 16'h0000;
    instr_use_imm = 1'b0;
    instr_wb      = 1'b0;
    dbg_addr      = 4'd0;

    repeat (2) @(negedge clk);
    check("reset done", done, 0);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset ready", instr_ready, 1);
    check("reset psr", psr, 0);
    check("reset done after", done, 0);
    check("reset alu_a", alu_a, 0);
    check("reset alu_b", alu_b, 0);
    check("reset alu_opcode", alu_opcode, 0);
    check_all_regs("reset");

    for (int v = 0; v < 8; v++) begin
      run_instr(vecs[v].op, vecs[v].rd, vecs[v].rs, vecs[v].imm, vecs[v].ui, vecs[v].wb,
                $sformatf("vec%0d", v), ga, gb, gp, gd);
      check($sformatf("vec%0d tbl a", v), ga, vecs[v].exp_a);
      check($sformatf("vec%0d tbl b", v), gb, vecs[v].exp_b);
      check($sformatf("vec%0d tbl psr", v), gp, vecs[v].exp_psr);
      check($sformatf("vec%0d tbl dst", v), gd, vecs[v].exp_dst);
    end
    check_all_regs("table");

    // ALU drive outputs keep their last values while idle.
    @(negedge clk);
    check("idle hold alu_opcode", alu_opcode, 8'h33);

    // Back-to-back offers: valid held high, fields changing every cycle.
    @(posedge clk);
    #1;
    n_done = 0;
    instr_valid   = 1'b1;
    instr_opcode  = 8'h05;
    instr_rdest   = 4'($urandom);
    instr_rsrc    = 4'($urandom);
    instr_imm     = 16'($urandom);
    instr_use_imm = 1'($urandom);
    instr_wb      = 1'b1;
    for (int cyc = 0; cyc < 16; cyc++) begin
      @(negedge clk);
      if (done) n_done++;
      if (instr_ready) begin
        accepts.push_back(cyc);
        model_exec(instr_opcode, instr_rdest, instr_rsrc, instr_imm, instr_use_imm, instr_wb);
      end
      @(posedge clk);
      #1;
      instr_opcode  = ($urandom_range(0, 1) == 0) ? 8'h05 : 8'h33;
      instr_rdest   = 4'($urandom);
      instr_rsrc    = 4'($urandom);
      instr_imm     = 16'($urandom);
      instr_use_imm = 1'($urandom);
      instr_wb      = 1'b1;
    end
    instr_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("hs accept count", accepts.size(), 4);
    check("hs done count", n_done, 4);
    ok_gap = 1;
    for (int i = 1; i < accepts.size(); i++) begin
      if (accepts[i] - accepts[i-1] != 4) ok_gap = 0;
    end
    check("hs accept spacing", ok_gap, 1);
    check("hs psr", psr, m_psr);
    check_all_regs("hs");

    // Randomized instructions against the model.
    for (int t = 0; t < 40; t++) begin
      run_instr(($urandom_range(0, 1) == 0) ? 8'h05 : 8'h33, 4'($urandom), 4'($urandom),
                ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom),
                1'($urandom), 1'($urandom_range(0, 3) != 0),
                $sformatf("rnd%0d", t), ga, gb, gp, gd);
    end
    check_all_regs("rnd");

    // Reset asserted during EXEC aborts the instruction.
    @(negedge clk);
    instr_opcode  = 8'h05;
    instr_rdest   = 4'd5;
    instr_rsrc    = 4'd6;
    instr_imm     = 16'h1234;
    instr_use_imm = 1'b1;
    instr_wb      = 1'b1;
    instr_valid   = 1'b1;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midrst in exec", instr_ready, 0);
    reset_n = 1'b0;
    n_done = 0;
    repeat (2) begin
      @(negedge clk);
      if (done) n_done++;
    end
    reset_n = 1'b1;
    for (int i = 0; i < 16; i++) m_reg[i] = 16'h0000;
    m_psr = 5'b00000;
    repeat (3) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check("midrst done pulses", n_done, 0);
    check("midrst ready", instr_ready, 1);
    check("midrst psr", psr, 0);
    check("midrst alu_a", alu_a, 0);
    check_all_regs("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
